imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared processor constants and loader state encoding
//
// Purpose: constants and the loader FSM state type shared by the
//          instruction-memory loader and the processor around it.
// Contents: BYTES_PER_WORD, BYTE_IDX_W, loader_state_t.
package imem_loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      RUN   = 2'd3
   } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream to instruction-memory program loader
//
// Purpose: packs a big-endian byte stream into 32-bit words, writes them to
//          instruction memory and holds the processor in reset until the
//          whole program is loaded.
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   start               one-cycle pulse starting a load (honoured in IDLE/RUN)
//   in_valid, in_data,
//   in_last, in_ready   byte stream with valid/ready handshake
//   wren_imem,
//   address_imem,
//   data_imem           instruction-memory write port
//   proc_reset          processor held in reset while high
//   word_count          words written in the current or last load
//   overflow            sticky: bytes dropped because memory was full
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DEPTH      = 4096
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  wren_imem,
   output logic [ADDR_WIDTH-1:0] address_imem,
   output logic [31:0]           data_imem,
   output logic                  proc_reset,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic                  overflow
);

   localparam logic [ADDR_WIDTH:0]   COUNT_MAX = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [BYTE_IDX_W-1:0] LAST_IDX  = BYTE_IDX_W'(BYTES_PER_WORD - 1);

   loader_state_t         state;
   loader_state_t         next_state;
   logic [BYTE_IDX_W-1:0] byte_idx;
   logic [31:0]           word_buf;
   logic                  last_flag;
   logic [ADDR_WIDTH-1:0] address;
   logic [ADDR_WIDTH:0]   count;
   logic                  ovf;

   logic mem_full;
   logic accept;
   logic word_end;

   assign mem_full = (count == COUNT_MAX);
   assign accept   = in_valid && (state == LOAD);
   assign word_end = (byte_idx == LAST_IDX) || in_last;

   assign address_imem = address;
   assign data_imem    = word_buf;
   assign word_count   = count;
   assign overflow     = ovf;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      wren_imem  = 1'b0;
      proc_reset = 1'b1;
      case (state)
         IDLE: begin
            if (start) next_state = LOAD;
         end
         LOAD: begin
            in_ready = 1'b1;
            if (accept) begin
               // Once memory is full, bytes are swallowed; only in_last matters.
               if (mem_full) begin
                  if (in_last) next_state = RUN;
               end else if (word_end) begin
                  next_state = WRITE;
               end
            end
         end
         WRITE: begin
            wren_imem  = 1'b1;
            next_state = last_flag ? RUN : LOAD;
         end
         RUN: begin
            proc_reset = 1'b0;
            if (start) next_state = LOAD;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         byte_idx  <= '0;
         word_buf  <= '0;
         last_flag <= 1'b0;
         address   <= '0;
         count     <= '0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE, RUN: begin
               if (start) begin
                  byte_idx  <= '0;
                  last_flag <= 1'b0;
                  address   <= '0;
                  count     <= '0;
                  ovf       <= 1'b0;
               end
            end
            LOAD: begin
               if (accept) begin
                  if (mem_full) begin
                     ovf <= 1'b1;
                  end else begin
                     // Byte 0 clears the low bytes so a short final word is zero-padded.
                     case (byte_idx)
                        BYTE_IDX_W'(0): word_buf        <= {in_data, 24'h0};
                        BYTE_IDX_W'(1): word_buf[23:16] <= in_data;
                        BYTE_IDX_W'(2): word_buf[15:8]  <= in_data;
                        default:        word_buf[7:0]   <= in_data;
                     endcase
                     last_flag <= in_last;
                     byte_idx  <= word_end ? '0 : byte_idx + 1'b1;
                  end
               end
            end
            WRITE: begin
               count <= count + 1'b1;
               if (address != ADDR_MAX) address <= address + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
